// File: rtl/uart_cmd_rx.sv
// UART receiver (8N1, 16x oversampled) with an ASCII command decoder that emits
// single-cycle remote-control pulses for the watch/stopwatch top level.
module uart_cmd_rx #(
    parameter int unsigned CLK_HZ = 100_000_000,
    parameter int unsigned BAUD   = 9600,
    parameter int unsigned OVS    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       u_rst,
    output logic       u_runstop,
    output logic       u_clear,
    output logic       u_up,
    output logic       u_down,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       frame_err
);

    localparam int unsigned DIV   = CLK_HZ / (BAUD * OVS);
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(DIV - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

    state_e           state_q, state_d;
    logic             rx_meta_q, rx_s;
    logic [DIV_W-1:0] div_q;
    logic             tick;
    logic [3:0]       tcnt_q, tcnt_d;
    logic [2:0]       bcnt_q, bcnt_d;
    logic [7:0]       sh_q, sh_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             done_q, done_d;
    logic             ferr_q, ferr_d;
    // {u_rst, u_runstop, u_clear, u_up, u_down}
    logic [4:0]       cmd_q, cmd_d;

    function automatic logic [4:0] decode(input logic [7:0] b);
        case (b)
            8'h1B:        decode = 5'b10000;
            8'h72, 8'h52: decode = 5'b01000;
            8'h63, 8'h43: decode = 5'b00100;
            8'h75, 8'h55: decode = 5'b00010;
            8'h64, 8'h44: decode = 5'b00001;
            default:      decode = 5'b00000;
        endcase
    endfunction

    assign tick = (div_q == DIV_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q <= 1'b1;
            rx_s      <= 1'b1;
            div_q     <= '0;
        end else begin
            rx_meta_q <= rx;
            rx_s      <= rx_meta_q;
            div_q     <= tick ? '0 : div_q + 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        tcnt_d    = tcnt_q;
        bcnt_d    = bcnt_q;
        sh_d      = sh_q;
        rx_data_d = rx_data_q;
        done_d    = 1'b0;
        ferr_d    = 1'b0;
        cmd_d     = 5'b00000;
        if (tick) begin
            unique case (state_q)
                StIdle: begin
                    if (!rx_s) begin
                        state_d = StStart;
                        tcnt_d  = 4'd0;
                    end
                end
                StStart: begin
                    if (tcnt_q == 4'd7) begin
                        if (rx_s) begin
                            state_d = StIdle;
                        end else begin
                            state_d = StData;
                            tcnt_d  = 4'd0;
                            bcnt_d  = 3'd0;
                        end
                    end else begin
                        tcnt_d = tcnt_q + 4'd1;
                    end
                end
                StData: begin
                    // tcnt wraps 15 -> 0, so each bit window is exactly 16 ticks
                    tcnt_d = tcnt_q + 4'd1;
                    if (tcnt_q == 4'd15) begin
                        sh_d = {rx_s, sh_q[7:1]};
                        if (bcnt_q == 3'd7) begin
                            state_d = StStop;
                        end else begin
                            bcnt_d = bcnt_q + 3'd1;
                        end
                    end
                end
                StStop: begin
                    tcnt_d = tcnt_q + 4'd1;
                    if (tcnt_q == 4'd15) begin
                        if (rx_s) begin
                            rx_data_d = sh_q;
                            done_d    = 1'b1;
                            cmd_d     = decode(sh_q);
                            state_d   = StIdle;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = StBreak;
                        end
                    end
                end
                StBreak: begin
                    if (rx_s) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            tcnt_q    <= 4'd0;
            bcnt_q    <= 3'd0;
            sh_q      <= 8'h00;
            rx_data_q <= 8'h00;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
            cmd_q     <= 5'b00000;
        end else begin
            state_q   <= state_d;
            tcnt_q    <= tcnt_d;
            bcnt_q    <= bcnt_d;
            sh_q      <= sh_d;
            rx_data_q <= rx_data_d;
            done_q    <= done_d;
            ferr_q    <= ferr_d;
            cmd_q     <= cmd_d;
        end
    end

    assign {u_rst, u_runstop, u_clear, u_up, u_down} = cmd_q;
    assign rx_data   = rx_data_q;
    assign rx_done   = done_q;
    assign frame_err = ferr_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx: expected output events are queued as frames are
// driven and popped by a monitor whenever the DUT pulses any output.
module tb_uart_cmd_rx;

    localparam int BIT = 160;  // cycles per bit at CLK_HZ=1.6M, BAUD=10k

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, rx;
    logic       u_rst, u_runstop, u_clear, u_up, u_down, rx_done, frame_err;
    logic [7:0] rx_data;

    logic       rst0, rx0;
    logic       u_rst0, u_runstop0, u_clear0, u_up0, u_down0, rx_done0, frame_err0;
    logic [7:0] rx_data0;

    uart_cmd_rx #(.CLK_HZ(1_600_000), .BAUD(10_000), .OVS(16)) dut (
        .clk(clk), .rst(rst), .rx(rx),
        .u_rst(u_rst), .u_runstop(u_runstop), .u_clear(u_clear), .u_up(u_up),
        .u_down(u_down), .rx_data(rx_data), .rx_done(rx_done), .frame_err(frame_err)
    );

    uart_cmd_rx dut_def (
        .clk(clk), .rst(rst0), .rx(rx0),
        .u_rst(u_rst0), .u_runstop(u_runstop0), .u_clear(u_clear0), .u_up(u_up0),
        .u_down(u_down0), .rx_data(rx_data0), .rx_done(rx_done0), .frame_err(frame_err0)
    );

    typedef struct {
        string       tag;
        logic [14:0] v;  // {frame_err, rx_done, u_rst, u_runstop, u_clear, u_up, u_down, rx_data}
    } ev_t;

    ev_t         sb[$];
    ev_t         ev;
    logic [14:0] obs;
    int          checks = 0;
    int          errors = 0;
    logic        mon_en = 1'b0;

    always @(negedge clk) begin
        if (rst && mon_en) begin
            obs = {frame_err, rx_done, u_rst, u_runstop, u_clear, u_up, u_down, rx_data};
            if (obs[14:8] != 7'd0) begin
                checks++;
                assert (sb.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_output observed=%h expected=none", obs);
                end
                if (sb.size() != 0) begin
                    ev = sb.pop_front();
                    checks++;
                    assert (obs === ev.v) else begin
                        errors++;
                        $error("FAIL %s observed=%h expected=%h", ev.tag, obs, ev.v);
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic push(input string tag, input logic ferr, input logic done,
                        input logic [4:0] cmd, input logic [7:0] d);
        ev_t e;
        e.tag = tag;
        e.v   = {ferr, done, cmd, d};
        sb.push_back(e);
    endtask

    task automatic send(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT) @(negedge clk);
        end
        rx = stop;
        repeat (BIT) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 4 * BIT && sb.size() != 0; i++) @(negedge clk);
        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL %s_timeout observed_pending=%0d expected=0", tag, sb.size());
            sb.delete();
        end
    endtask

    logic [7:0] cmd_bytes[5];
    logic [4:0] cmd_exp[5];
    logic [6:0] any0;
    logic [7:0] rb;

    initial begin
        cmd_bytes = '{8'h72, 8'h43, 8'h75, 8'h44, 8'h1B};
        cmd_exp   = '{5'b01000, 5'b00100, 5'b00010, 5'b00001, 5'b10000};

        // Reset held with a toggling line, then a long idle
        rst = 1'b0; rst0 = 1'b0; rx = 1'b1; rx0 = 1'b1;
        repeat (50) begin
            @(negedge clk);
            rx  = ~rx;
            rx0 = ~rx0;
        end
        chk("reset_outs", {u_rst, u_runstop, u_clear, u_up, u_down, rx_done, frame_err}, 0);
        chk("reset_data", rx_data, 8'h00);
        chk("reset_outs_def",
            {u_rst0, u_runstop0, u_clear0, u_up0, u_down0, rx_done0, frame_err0}, 0);
        rx = 1'b1; rx0 = 1'b1;
        @(negedge clk);
        rst = 1'b1; rst0 = 1'b1; mon_en = 1'b1;
        any0 = '0;
        repeat (2000) begin
            @(negedge clk);
            any0 = any0 | {u_rst0, u_runstop0, u_clear0, u_up0, u_down0, rx_done0, frame_err0};
        end
        chk("idle_outs_def", any0, 0);
        chk("idle_data_def", rx_data0, 8'h00);
        chk("idle_data", rx_data, 8'h00);

        // Back-to-back command bytes
        for (int i = 0; i < 5; i++) begin
            push($sformatf("cmd%0d", i), 1'b0, 1'b1, cmd_exp[i], cmd_bytes[i]);
            send(cmd_bytes[i], 1'b1);
        end
        drain("cmds");

        // Unrecognised byte
        push("unknown", 1'b0, 1'b1, 5'b00000, 8'h7A);
        send(8'h7A, 1'b1);
        drain("unknown");

        // Framing error followed by a held-low line, then a good 'c'
        push("frame_err", 1'b1, 1'b0, 5'b00000, 8'h7A);
        send(8'h72, 1'b0);
        rx = 1'b0;
        repeat (3 * BIT) @(negedge clk);
        rx = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        drain("frame_err");
        chk("ferr_data_hold", rx_data, 8'h7A);
        push("after_ferr", 1'b0, 1'b1, 5'b00100, 8'h63);
        send(8'h63, 1'b1);
        drain("after_ferr");

        // Short low glitch must not start a frame
        rx = 1'b0;
        repeat (40) @(negedge clk);
        rx = 1'b1;
        repeat (3 * BIT) @(negedge clk);
        chk("glitch_data", rx_data, 8'h63);
        push("after_glitch", 1'b0, 1'b1, 5'b00010, 8'h55);
        send(8'h55, 1'b1);
        drain("after_glitch");

        // Reset in the middle of bit 4 of 'R'
        rb = 8'h52;
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = rb[i];
            repeat (BIT) @(negedge clk);
        end
        rx = rb[4];
        repeat (BIT / 2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("midrst_outs", {u_rst, u_runstop, u_clear, u_up, u_down, rx_done, frame_err}, 0);
        chk("midrst_data", rx_data, 8'h00);
        rx = 1'b1;
        rst = 1'b1;
        repeat (12 * BIT) @(negedge clk);
        chk("midrst_aborted", rx_data, 8'h00);
        push("resend_R", 1'b0, 1'b1, 5'b01000, 8'h52);
        send(8'h52, 1'b1);
        drain("resend_R");
        repeat (2 * BIT) @(negedge clk);
        chk("final_data", rx_data, 8'h52);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
